// File: rtl/fma_buf_pkg.sv
// Shared types and constants for the FMA ping-pong operand buffer.
// The 3-bit per-lane write mask is ordered {a_v, b_v, c_v}. Operands are packed
// {a, b, c}, with a in the MSBs, so mask bit k selects operand field k.
package fma_buf_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } buf_state_e;

  localparam int A_IDX = 2;
  localparam int B_IDX = 1;
  localparam int C_IDX = 0;

endpackage

// File: rtl/fma_buf_bank.sv
// One operand bank: FMA_COUNT lanes of {a,b,c} with a written-flag per field.
// Flags record which fields have been written since the last clear.
// complete_nx_o reports completeness as it would be after this cycle's write.
module fma_buf_bank
  import fma_buf_pkg::*;
#(
  parameter int FMA_COUNT = 2,
  parameter int WIDTH     = 16
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                clr_i,
  input  logic                                wr_en_i,
  input  logic [FMA_COUNT-1:0][3*WIDTH-1:0]   wr_data_i,
  input  logic [FMA_COUNT-1:0][2:0]           wr_mask_i,
  output logic [FMA_COUNT-1:0][3*WIDTH-1:0]   data_o,
  output logic [FMA_COUNT-1:0]                c_flag_o,
  output logic                                complete_o,
  output logic                                complete_nx_o
);

  logic [FMA_COUNT-1:0][3*WIDTH-1:0] data_q;
  logic [FMA_COUNT-1:0][2:0]         flag_q;

  // Clear has priority; otherwise each masked field is overwritten and flagged.
  always_ff @(posedge clk_in) begin
    if (rst_in || clr_i) begin
      data_q <= '0;
      flag_q <= '0;
    end else if (wr_en_i) begin
      for (int l = 0; l < FMA_COUNT; l++) begin
        for (int f = 0; f < 3; f++) begin
          if (wr_mask_i[l][f]) begin
            data_q[l][f*WIDTH +: WIDTH] <= wr_data_i[l][f*WIDTH +: WIDTH];
            flag_q[l][f]                <= 1'b1;
          end
        end
      end
    end
  end

  // Completeness needs a and b on every lane; c is optional (accumulator reuse).
  always_comb begin
    complete_o    = 1'b1;
    complete_nx_o = 1'b1;
    c_flag_o      = '0;
    for (int l = 0; l < FMA_COUNT; l++) begin
      c_flag_o[l]   = flag_q[l][C_IDX];
      complete_o    = complete_o & flag_q[l][A_IDX] & flag_q[l][B_IDX];
      complete_nx_o = complete_nx_o
                    & (flag_q[l][A_IDX] | (wr_en_i & wr_mask_i[l][A_IDX]))
                    & (flag_q[l][B_IDX] | (wr_en_i & wr_mask_i[l][B_IDX]));
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/fma_pingpong_buffer.sv
// Ping-pong operand staging buffer feeding FMA_COUNT FMA lanes.
// Two physical banks; sel_q names the fill bank, the other is the output bank.
// A swap just flips sel_q and clears the old output bank, so nothing is copied.
// Optional macro FMA_BUF_STATS_EN adds stall_count_out (stalled write cycles).
module fma_pingpong_buffer
  import fma_buf_pkg::*;
#(
  parameter int FMA_COUNT = 2,
  parameter int WIDTH     = 16
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic [FMA_COUNT-1:0][3*WIDTH-1:0]   abc_in,
  input  logic [FMA_COUNT-1:0][2:0]           abc_valid_in,
  output logic                                in_ready_out,
  output logic [FMA_COUNT-1:0][3*WIDTH-1:0]   fma_out,
  output logic [FMA_COUNT-1:0]                fma_c_valid,
  output logic                                fma_out_valid,
  input  logic                                fma_ready_in
`ifdef FMA_BUF_STATS_EN
  ,
  output logic [15:0]                         stall_count_out
`endif
);

  buf_state_e state_q, state_d;
  logic       sel_q, sel_d;
  logic       swap, drop;
  logic       wr_acc;
  logic       fill_cmp_q, fill_cmp_nx;

  logic [FMA_COUNT-1:0][3*WIDTH-1:0] bank_data [2];
  logic [FMA_COUNT-1:0]              bank_cflag [2];
  logic [1:0]                        bank_cmp, bank_cmp_nx, bank_wr, bank_clr;

  for (genvar k = 0; k < 2; k++) begin : g_bank
    assign bank_wr[k]  = wr_acc && (sel_q == 1'(k));
    assign bank_clr[k] = (swap || drop) && (sel_q != 1'(k));

    fma_buf_bank #(
      .FMA_COUNT(FMA_COUNT),
      .WIDTH    (WIDTH)
    ) u_bank (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .clr_i        (bank_clr[k]),
      .wr_en_i      (bank_wr[k]),
      .wr_data_i    (abc_in),
      .wr_mask_i    (abc_valid_in),
      .data_o       (bank_data[k]),
      .c_flag_o     (bank_cflag[k]),
      .complete_o   (bank_cmp[k]),
      .complete_nx_o(bank_cmp_nx[k])
    );
  end

  assign fill_cmp_q  = bank_cmp[sel_q];
  assign fill_cmp_nx = bank_cmp_nx[sel_q];

  // Back-pressure only when a finished set is waiting behind a stalled output.
  assign in_ready_out = !((state_q == HOLD) && fill_cmp_q && !fma_ready_in);
  assign wr_acc       = in_ready_out && !rst_in;

  assign fma_out       = bank_data[~sel_q];
  assign fma_c_valid   = bank_cflag[~sel_q];
  assign fma_out_valid = (state_q == HOLD);

  // Next-state: issue on completion, drop the output bank once it is consumed.
  always_comb begin
    state_d = state_q;
    swap    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (fill_cmp_nx) begin
          swap    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (fma_ready_in) begin
          if (fill_cmp_nx) begin
            swap = 1'b1;
          end else begin
            drop    = 1'b1;
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
    sel_d = swap ? ~sel_q : sel_q;
  end

  // State and bank-select registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= EMPTY;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

`ifdef FMA_BUF_STATS_EN
  logic [15:0] stall_cnt_q;

  // Count cycles where a write was offered but back-pressured; saturates.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stall_cnt_q <= '0;
    end else if ((|abc_valid_in) && !in_ready_out && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_count_out = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fma_pingpong_buffer.sv
// Scoreboard bench for fma_pingpong_buffer (FMA_COUNT=2, WIDTH=16).
// The reference model tracks the fill image per lane/field and pushes every
// issued set to a queue; a negedge monitor checks the DUT outputs against it.
// Define FMA_BUF_STATS_EN to also check stall_count_out.
module tb_fma_pingpong_buffer;
  localparam int F = 2;
  localparam int W = 16;

  typedef logic [F-1:0][2:0]     mask_t;
  typedef logic [F-1:0][3*W-1:0] data_t;
  typedef struct {
    data_t        d;
    logic [F-1:0] cv;
  } set_t;

  logic  clk_in = 1'b0;
  logic  rst_in;
  data_t abc_in;
  mask_t abc_valid_in;
  logic  in_ready_out;
  data_t fma_out;
  logic [F-1:0] fma_c_valid;
  logic  fma_out_valid;
  logic  fma_ready_in;
`ifdef FMA_BUF_STATS_EN
  logic [15:0] stall_count_out;
`endif

  fma_pingpong_buffer #(.FMA_COUNT(F), .WIDTH(W)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .abc_in       (abc_in),
    .abc_valid_in (abc_valid_in),
    .in_ready_out (in_ready_out),
    .fma_out      (fma_out),
    .fma_c_valid  (fma_c_valid),
    .fma_out_valid(fma_out_valid),
    .fma_ready_in (fma_ready_in)
`ifdef FMA_BUF_STATS_EN
    ,
    .stall_count_out(stall_count_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: fill image, issue state, expected outputs.
  logic [W-1:0] m_val [F][3];
  logic         m_flg [F][3];
  logic         m_hold = 1'b0;
  logic [15:0]  m_stall = '0;
  logic         exp_in_ready = 1'b1;
  logic         exp_valid = 1'b0;
  logic         mon_en = 1'b0;
  set_t         exp_q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3*W-1:0] abc(input int a, input int b, input int c);
    return {W'(a), W'(b), W'(c)};
  endfunction

  function automatic set_t mk_set();
    set_t s;
    for (int l = 0; l < F; l++) begin
      s.d[l]  = {m_val[l][2], m_val[l][1], m_val[l][0]};
      s.cv[l] = m_flg[l][0];
    end
    return s;
  endfunction

  function automatic void clear_fill();
    for (int l = 0; l < F; l++)
      for (int f = 0; f < 3; f++) begin
        m_val[l][f] = '0;
        m_flg[l][f] = 1'b0;
      end
  endfunction

  // Apply one cycle of inputs and advance the model across the next edge.
  task automatic step(input logic r, input mask_t m, input data_t d, input logic rdy);
    logic [W-1:0] nv [F][3];
    logic         nf [F][3];
    logic         done, acc, cmp;
    rst_in = r; abc_valid_in = m; abc_in = d; fma_ready_in = rdy;
    done = 1'b1;
    for (int l = 0; l < F; l++) done &= m_flg[l][2] & m_flg[l][1];
    exp_in_ready = !(m_hold && done && !rdy);
    exp_valid    = m_hold;
    acc = exp_in_ready && !r;
    nv = m_val;
    nf = m_flg;
    if (acc)
      for (int l = 0; l < F; l++)
        for (int f = 0; f < 3; f++)
          if (m[l][f]) begin
            nv[l][f] = d[l][f*W +: W];
            nf[l][f] = 1'b1;
          end
    cmp = 1'b1;
    for (int l = 0; l < F; l++) cmp &= nf[l][2] & nf[l][1];
    @(posedge clk_in);
    if (r) begin
      clear_fill();
      m_hold = 1'b0;
      m_stall = '0;
      exp_q.delete();
    end else begin
      if ((|m) && !exp_in_ready && m_stall != 16'hFFFF) m_stall++;
      m_val = nv;
      m_flg = nf;
      if (cmp && (!m_hold || rdy)) begin
        exp_q.push_back(mk_set());
        clear_fill();
        m_hold = 1'b1;
      end else if (m_hold && rdy) begin
        m_hold = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, '0, rdy);
  endtask

  task automatic do_reset();
    step(1'b1, '0, '0, 1'b0);
  endtask

  // Monitor: compares the presented outputs against the scoreboard each cycle.
  initial begin
    forever begin
      @(negedge clk_in);
      if (mon_en) begin
        chk("in_ready", in_ready_out, exp_in_ready);
        chk("out_valid", fma_out_valid, exp_valid);
`ifdef FMA_BUF_STATS_EN
        chk("stall_count", stall_count_out, m_stall);
`endif
        if (fma_out_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_issue: valid high with no expected set at %0t", $time);
          end else begin
            chk("fma_out", fma_out, exp_q[0].d);
            chk("c_valid", fma_c_valid, exp_q[0].cv);
            if (fma_ready_in === 1'b1) void'(exp_q.pop_front());
          end
        end else begin
          chk("idle_out", fma_out, '0);
          chk("idle_cvalid", fma_c_valid, '0);
        end
      end
    end
  end

  initial begin
    mask_t m;
    data_t d;
    int    gaps;
    clear_fill();
    do_reset();
    mon_en = 1'b1;
    do_reset();

    // Complete set in two writes; lane1 has no c.
    step(1'b0, {3'b000, 3'b111}, {abc(0, 0, 0), abc(1, 2, 3)}, 1'b0);
    chk("t31_pre_valid", fma_out_valid, 1'b0);
    step(1'b0, {3'b110, 3'b000}, {abc(4, 5, 99), abc(0, 0, 0)}, 1'b0);
    chk("t31_valid", fma_out_valid, 1'b1);
    chk("t31_out", fma_out, {abc(4, 5, 0), abc(1, 2, 3)});
    chk("t31_cvalid", fma_c_valid, 2'b01);
    idle(1'b1);
    chk("t31_drain", fma_out_valid, 1'b0);

    // Split writes and a rewritten a.
    do_reset();
    step(1'b0, {3'b000, 3'b100}, {abc(0, 0, 0), abc(7, 0, 0)}, 1'b0);
    step(1'b0, {3'b000, 3'b010}, {abc(0, 0, 0), abc(0, 2, 0)}, 1'b0);
    step(1'b0, {3'b000, 3'b100}, {abc(0, 0, 0), abc(9, 0, 0)}, 1'b0);
    step(1'b0, {3'b000, 3'b001}, {abc(0, 0, 0), abc(0, 0, 3)}, 1'b0);
    chk("t32_not_yet", fma_out_valid, 1'b0);
    step(1'b0, {3'b110, 3'b000}, {abc(4, 5, 0), abc(0, 0, 0)}, 1'b0);
    chk("t32_valid", fma_out_valid, 1'b1);
    chk("t32_a", fma_out[0][3*W-1:2*W], 16'd9);
    idle(1'b1);

    // Output stalled while the second set completes.
    do_reset();
    step(1'b0, {3'b111, 3'b111}, {abc(4, 5, 6), abc(1, 2, 3)}, 1'b0);
    step(1'b0, {3'b110, 3'b110}, {abc(12, 13, 0), abc(10, 11, 0)}, 1'b0);
    chk("t33_ready_low", in_ready_out, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, {3'b111, 3'b111}, {abc(8, 8, 8), abc(8, 8, 8)}, 1'b0);
`ifdef FMA_BUF_STATS_EN
    chk("t36_stall3", stall_count_out, 16'd3);
`endif
    chk("t33_held", fma_out, {abc(4, 5, 6), abc(1, 2, 3)});
    idle(1'b0);
    idle(1'b1);
    chk("t33_valid", fma_out_valid, 1'b1);
    chk("t33_second", fma_out, {abc(12, 13, 0), abc(10, 11, 0)});
    chk("t33_cvalid", fma_c_valid, 2'b00);
    idle(1'b1);

    // Back-to-back issue with ready tied high.
    do_reset();
    gaps = 0;
    for (int i = 0; i < 20; i++) begin
      for (int l = 0; l < F; l++) d[l] = abc($urandom, $urandom, $urandom);
      step(1'b0, {3'b111, 3'b111}, d, 1'b1);
      if (fma_out_valid !== 1'b1) gaps++;
    end
    chk("t34_gaps", gaps, 0);
    idle(1'b1);

    // Reset in HOLD with a partial fill.
    do_reset();
    step(1'b0, {3'b111, 3'b111}, {abc(2, 2, 2), abc(1, 1, 1)}, 1'b0);
    step(1'b0, {3'b000, 3'b111}, {abc(0, 0, 0), abc(7, 7, 7)}, 1'b0);
    step(1'b1, {3'b110, 3'b000}, {abc(5, 6, 0), abc(0, 0, 0)}, 1'b0);
    chk("t35_valid", fma_out_valid, 1'b0);
    chk("t35_out", fma_out, '0);
    chk("t35_cvalid", fma_c_valid, '0);
    chk("t35_ready", in_ready_out, 1'b1);
    step(1'b0, {3'b110, 3'b000}, {abc(5, 6, 0), abc(0, 0, 0)}, 1'b0);
    chk("t35_no_stale", fma_out_valid, 1'b0);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int l = 0; l < F; l++) begin
        m[l] = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
        d[l] = abc($urandom, $urandom, $urandom);
      end
      step(($urandom_range(0, 149) == 0), m, d, ($urandom_range(0, 9) < 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
